// File: rtl/pmem_burst_pkg.sv
// Shared types, sizes and address helper for the pmem burst adapter.
package pmem_burst_pkg;

  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned S_OFFSET  = 5;
  localparam int unsigned S_LINE    = 256;
  localparam int unsigned S_BEAT    = 64;
  localparam int unsigned NUM_BEATS = S_LINE / S_BEAT;
  localparam int unsigned CNT_W     = $clog2(NUM_BEATS);

  typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, DONE} burst_state_t;

  // Clear the offset bits so every burst starts on a line boundary.
  function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:S_OFFSET], S_OFFSET'(0)};
  endfunction

endpackage

// File: rtl/pmem_burst_adapter_if.sv
// Cache-side line port and memory-side burst port of the adapter.
interface pmem_burst_adapter_if;
  import pmem_burst_pkg::*;

  logic              line_read_i;
  logic              line_write_i;
  logic [ADDR_W-1:0] line_addr_i;
  logic [S_LINE-1:0] line_wdata_i;
  logic [S_LINE-1:0] line_rdata_o;
  logic              line_resp_o;
  logic              burst_read_o;
  logic              burst_write_o;
  logic [ADDR_W-1:0] burst_addr_o;
  logic [S_BEAT-1:0] burst_wdata_o;
  logic [S_BEAT-1:0] burst_rdata_i;
  logic              burst_resp_i;

  // Environment side: cache requester plus burst memory.
  modport master (
    output line_read_i, line_write_i, line_addr_i, line_wdata_i,
    input  line_rdata_o, line_resp_o,
    input  burst_read_o, burst_write_o, burst_addr_o, burst_wdata_o,
    output burst_rdata_i, burst_resp_i
  );

  // Adapter side.
  modport slave (
    input  line_read_i, line_write_i, line_addr_i, line_wdata_i,
    output line_rdata_o, line_resp_o,
    output burst_read_o, burst_write_o, burst_addr_o, burst_wdata_o,
    input  burst_rdata_i, burst_resp_i
  );

endinterface

// File: rtl/pmem_line_buffer.sv
// One cache line of storage with a full-line load, a beat-indexed write and a beat-indexed read mux.
module pmem_line_buffer
  import pmem_burst_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load_en,
  input  logic [S_LINE-1:0] load_line,
  input  logic             beat_we,
  input  logic [CNT_W-1:0]  beat_idx,
  input  logic [S_BEAT-1:0] beat_d,
  output logic [S_LINE-1:0] line_q,
  output logic [S_BEAT-1:0] beat_q
);

  // Line storage: full load has priority over a single-beat update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_q <= '0;
    end else if (load_en) begin
      line_q <= load_line;
    end else if (beat_we) begin
      line_q[S_BEAT*beat_idx +: S_BEAT] <= beat_d;
    end
  end

  // Beat selected by the burst counter.
  always_comb begin
    beat_q = line_q[S_BEAT*beat_idx +: S_BEAT];
  end

endmodule

// File: rtl/pmem_burst_adapter.sv
// Converts single 256-bit line reads/writes into 4 x 64-bit memory bursts.
module pmem_burst_adapter
  import pmem_burst_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  pmem_burst_adapter_if.slave  bus
);

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_BEATS - 1);

  burst_state_t      state;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] addr_q;
  logic              rd_active;
  logic              wr_active;
  logic              resp_q;
  logic [S_LINE-1:0] rd_line;
  logic [S_BEAT-1:0] wr_beat;
  logic [S_BEAT-1:0] rd_beat_unused;
  logic [S_LINE-1:0] wr_line_unused;

  // FSM, beat counter, address latch and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      addr_q    <= '0;
      rd_active <= 1'b0;
      wr_active <= 1'b0;
      resp_q    <= 1'b0;
    end else begin
      resp_q <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (bus.line_write_i) begin
            state     <= WR_BURST;
            addr_q    <= line_align(bus.line_addr_i);
            wr_active <= 1'b1;
          end else if (bus.line_read_i) begin
            state     <= RD_BURST;
            addr_q    <= line_align(bus.line_addr_i);
            rd_active <= 1'b1;
          end
        end
        RD_BURST: begin
          if (bus.burst_resp_i) begin
            cnt <= cnt + CNT_W'(1);
            if (cnt == LAST_BEAT) begin
              state     <= DONE;
              rd_active <= 1'b0;
              resp_q    <= 1'b1;
            end
          end
        end
        WR_BURST: begin
          if (bus.burst_resp_i) begin
            cnt <= cnt + CNT_W'(1);
            if (cnt == LAST_BEAT) begin
              state     <= DONE;
              wr_active <= 1'b0;
              resp_q    <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Read line assembly; holds the last filled line until the next read's first beat.
  pmem_line_buffer u_rd_buf (
    .clk       (clk),
    .rst       (rst),
    .load_en   (1'b0),
    .load_line ('0),
    .beat_we   (rd_active && bus.burst_resp_i),
    .beat_idx  (cnt),
    .beat_d    (bus.burst_rdata_i),
    .line_q    (rd_line),
    .beat_q    (rd_beat_unused)
  );

  // Writeback line latched at acceptance so input changes mid-burst are harmless.
  pmem_line_buffer u_wr_buf (
    .clk       (clk),
    .rst       (rst),
    .load_en   ((state == IDLE) && bus.line_write_i),
    .load_line (bus.line_wdata_i),
    .beat_we   (1'b0),
    .beat_idx  (cnt),
    .beat_d    ('0),
    .line_q    (wr_line_unused),
    .beat_q    (wr_beat)
  );

  assign bus.line_rdata_o  = rd_line;
  assign bus.line_resp_o   = resp_q;
  assign bus.burst_read_o  = rd_active;
  assign bus.burst_write_o = wr_active;
  assign bus.burst_addr_o  = addr_q;
  assign bus.burst_wdata_o = wr_active ? wr_beat : '0;

endmodule
